// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_ctrl_pkg
//  Description : Shared types and default widths for the RAM access sequencer
//                and arbiter.
//  Contents    : state_t - sequencer state encoding
//                c_ADDR_W_DEF / c_DATA_W_DEF - default RAM geometry
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

  localparam int c_ADDR_W_DEF = 8;
  localparam int c_DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage : ram_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-input round-robin arbiter with a 1-bit last-served
//                pointer. Grant is combinational and one-hot; the pointer
//                advances only when a grant is actually issued.
//  Ports       : i_clk    - clock
//                i_rst_n  - asynchronous active-low reset
//                i_req    - request vector (bit 0 = requester 0)
//                i_en     - grant qualifier; no grant while low
//                o_gnt    - one-hot grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // 1 = requester 1 was served last, so requester 0 wins the next tie.
  // Reset to 1 so the first tie after reset goes to requester 0.
  logic r_last_r1;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last_r1 ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_r1 <= 1'b1;
    end else if (|w_gnt) begin
      r_last_r1 <= w_gnt[1];
    end
  end

  assign o_gnt = w_gnt;

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_arbiter
//  Description : Round-robin arbiter and SETUP/STROBE/DONE sequencer in front
//                of a word RAM with an edge-triggered write enable. Address
//                and write data are registered one full cycle before the
//                strobe and held one full cycle after it.
//  Ports       : i_clk, i_rst_n             - clock, async active-low reset
//                i_rN_req/we/addr/wdata     - requester N command (N = 0, 1)
//                o_rN_ack                   - one-cycle completion pulse
//                o_rdata                    - data of last completed read
//                o_ram_address/wdata/we/re  - RAM control (all registered)
//                i_ram_rdata                - RAM read data (combinational)
//                o_busy                     - sequencer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_access_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DEF,
  parameter int DATA_W = c_DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_r0_req,
  input  logic              i_r0_we,
  input  logic [ADDR_W-1:0] i_r0_addr,
  input  logic [DATA_W-1:0] i_r0_wdata,
  output logic              o_r0_ack,
  input  logic              i_r1_req,
  input  logic              i_r1_we,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [DATA_W-1:0] i_r1_wdata,
  output logic              o_r1_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  output logic              o_ram_re,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy
);

  state_t r_state, w_state_nxt;

  logic              r_cmd_we,  w_cmd_we_nxt;
  logic              r_owner,   w_owner_nxt;   // 0 = requester 0, 1 = requester 1
  logic [ADDR_W-1:0] r_ram_address, w_ram_address_nxt;
  logic [DATA_W-1:0] r_ram_wdata,   w_ram_wdata_nxt;
  logic [DATA_W-1:0] r_rdata,       w_rdata_nxt;
  logic              r_ram_we,  w_ram_we_nxt;
  logic              r_ram_re,  w_ram_re_nxt;
  logic              r_r0_ack,  w_r0_ack_nxt;
  logic              r_r1_ack,  w_r1_ack_nxt;

  logic [1:0] w_gnt;
  logic       w_gnt_en;

  // Requests are only considered while idle.
  assign w_gnt_en = (r_state == IDLE);

  rr_arbiter2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   ({i_r1_req, i_r0_req}),
    .i_en    (w_gnt_en),
    .o_gnt   (w_gnt)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_we_nxt      = r_cmd_we;
    w_owner_nxt       = r_owner;
    w_ram_address_nxt = r_ram_address;
    w_ram_wdata_nxt   = r_ram_wdata;
    w_rdata_nxt       = r_rdata;
    w_ram_we_nxt      = 1'b0;
    w_ram_re_nxt      = 1'b0;
    w_r0_ack_nxt      = 1'b0;
    w_r1_ack_nxt      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_owner_nxt       = w_gnt[1];
          w_cmd_we_nxt      = w_gnt[1] ? i_r1_we    : i_r0_we;
          w_ram_address_nxt = w_gnt[1] ? i_r1_addr  : i_r0_addr;
          w_ram_wdata_nxt   = w_gnt[1] ? i_r1_wdata : i_r0_wdata;
          // Read enable is asserted from SETUP so the RAM output has
          // settled by the end of STROBE.
          w_ram_re_nxt      = ~w_cmd_we_nxt;
          w_state_nxt       = SETUP;
        end
      end
      SETUP: begin
        w_ram_we_nxt = r_cmd_we;
        w_ram_re_nxt = ~r_cmd_we;
        w_state_nxt  = STROBE;
      end
      STROBE: begin
        if (!r_cmd_we) begin
          w_rdata_nxt = i_ram_rdata;
        end
        w_r0_ack_nxt = ~r_owner;
        w_r1_ack_nxt = r_owner;
        w_state_nxt  = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_cmd_we      <= 1'b0;
      r_owner       <= 1'b0;
      r_ram_address <= '0;
      r_ram_wdata   <= '0;
      r_rdata       <= '0;
      r_ram_we      <= 1'b0;
      r_ram_re      <= 1'b0;
      r_r0_ack      <= 1'b0;
      r_r1_ack      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_we      <= w_cmd_we_nxt;
      r_owner       <= w_owner_nxt;
      r_ram_address <= w_ram_address_nxt;
      r_ram_wdata   <= w_ram_wdata_nxt;
      r_rdata       <= w_rdata_nxt;
      r_ram_we      <= w_ram_we_nxt;
      r_ram_re      <= w_ram_re_nxt;
      r_r0_ack      <= w_r0_ack_nxt;
      r_r1_ack      <= w_r1_ack_nxt;
    end
  end

  assign o_r0_ack      = r_r0_ack;
  assign o_r1_ack      = r_r1_ack;
  assign o_rdata       = r_rdata;
  assign o_ram_address = r_ram_address;
  assign o_ram_wdata   = r_ram_wdata;
  assign o_ram_we      = r_ram_we;
  assign o_ram_re      = r_ram_re;
  assign o_busy        = (r_state != IDLE);

endmodule : ram_access_arbiter
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_access_arbiter
//  Description : Directed self-checking bench for ram_access_arbiter with a
//                256x16 RAM model written on the rising edge of o_ram_we.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [7:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [15:0] rdata;
  logic [7:0]  ram_address;
  logic [15:0] ram_wdata;
  logic        ram_we, ram_re;
  logic [15:0] ram_rdata;
  logic        busy;

  int n_checks;
  int n_fail;
  int we_edges;
  logic tb_init;

  logic [15:0] mem [256];

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_r0_req      (r0_req),
    .i_r0_we       (r0_we),
    .i_r0_addr     (r0_addr),
    .i_r0_wdata    (r0_wdata),
    .o_r0_ack      (r0_ack),
    .i_r1_req      (r1_req),
    .i_r1_we       (r1_we),
    .i_r1_addr     (r1_addr),
    .i_r1_wdata    (r1_wdata),
    .o_r1_ack      (r1_ack),
    .o_rdata       (rdata),
    .o_ram_address (ram_address),
    .o_ram_wdata   (ram_wdata),
    .o_ram_we      (ram_we),
    .o_ram_re      (ram_re),
    .i_ram_rdata   (ram_rdata),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: edge-triggered write, combinational read.
  always @(posedge ram_we or posedge tb_init) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h30] = 16'h5A5A;
      we_edges = 0;
    end else begin
      mem[ram_address] = ram_wdata;
      we_edges = we_edges + 1;
    end
  end
  assign ram_rdata = mem[ram_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input logic req, input logic we,
                         input logic [7:0] addr, input logic [15:0] wd);
    if (who == 0) begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  // One transaction from a single requester, checked cycle by cycle.
  task automatic do_txn(input int who, input logic we, input logic [7:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_rd,
                        input bit drop_in_setup);
    set_req(who, 1'b1, we, addr, wd);
    chk("c0_busy", busy, 0);
    tick();                                   // cycle 1: SETUP
    if (drop_in_setup) set_req(who, 1'b0, we, 8'h00, 16'h0000);
    chk("c1_busy", busy, 1);
    chk("c1_addr", ram_address, addr);
    if (we) chk("c1_wdata", ram_wdata, wd);
    chk("c1_we", ram_we, 0);
    chk("c1_re", ram_re, !we);
    chk("c1_acks", {r1_ack, r0_ack}, 0);
    tick();                                   // cycle 2: STROBE
    chk("c2_addr", ram_address, addr);
    if (we) chk("c2_wdata", ram_wdata, wd);
    chk("c2_we", ram_we, we);
    chk("c2_re", ram_re, !we);
    chk("c2_acks", {r1_ack, r0_ack}, 0);
    tick();                                   // cycle 3: DONE / ack
    chk("c3_addr", ram_address, addr);
    if (we) chk("c3_wdata", ram_wdata, wd);
    chk("c3_we_re", {ram_we, ram_re}, 0);
    chk("c3_acks", {r1_ack, r0_ack}, (who == 0) ? 2'b01 : 2'b10);
    chk("c3_rdata", rdata, exp_rd);
    set_req(who, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();                                   // back to IDLE
    chk("c4_acks", {r1_ack, r0_ack}, 0);
    chk("c4_busy", busy, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    tb_init  = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1 tb_init = 1'b1;
    #1 tb_init = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", {r0_ack, r1_ack, ram_we, ram_re, busy}, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_rdata", rdata, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // r0 write 0x05 <- 0xBEEF, then r1 reads it back.
    do_txn(0, 1'b1, 8'h05, 16'hBEEF, 16'h0000, 1'b0);
    chk("mem05", mem[8'h05], 16'hBEEF);
    do_txn(1, 1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0);

    // Both requesting continuously: r0, r1, r0, r1.
    set_req(0, 1'b1, 1'b1, 8'h20, 16'h1111);
    set_req(1, 1'b1, 1'b1, 8'h21, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_addr", ram_address, (k % 2 == 0) ? 8'h20 : 8'h21);
      chk("rr_acks_s", {r1_ack, r0_ack}, 0);
      tick();
      chk("rr_acks_t", {r1_ack, r0_ack}, 0);
      tick();
      chk("rr_acks_d", {r1_ack, r0_ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 3) begin
        set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
      tick();
      chk("rr_acks_i", {r1_ack, r0_ack}, 0);
    end
    chk("rr_busy_end", busy, 0);
    chk("mem20", mem[8'h20], 16'h1111);
    chk("mem21", mem[8'h21], 16'h2222);
    chk("rr_we_edges", we_edges, 5);

    // r1 write with req dropped during SETUP still completes.
    do_txn(1, 1'b1, 8'h10, 16'hCAFE, 16'hBEEF, 1'b1);
    chk("mem10", mem[8'h10], 16'hCAFE);
    tick();
    chk("drop_no_repeat", {busy, r1_ack}, 0);

    // Reset during SETUP of an r0 write.
    set_req(0, 1'b1, 1'b1, 8'h30, 16'hDEAD);
    tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {r0_ack, r1_ack, ram_we, ram_re, busy}, 0);
    chk("mid_rst_addr", ram_address, 0);
    chk("mid_rst_wdata", ram_wdata, 0);
    chk("mid_rst_rdata", rdata, 0);
    set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick(); tick(); tick();
    chk("mid_rst_acks", {r1_ack, r0_ack}, 0);
    chk("mem30", mem[8'h30], 16'h5A5A);
    chk("mid_rst_we_edges", we_edges, 6);
    rst_n = 1'b1;
    tick();

    // First tie after reset goes to r0 (pointer was last-r0 before reset).
    set_req(0, 1'b1, 1'b0, 8'h05, 16'h0000);
    set_req(1, 1'b1, 1'b0, 8'h10, 16'h0000);
    tick();
    chk("tie_addr", ram_address, 8'h05);
    tick(); tick();
    chk("tie_acks", {r1_ack, r0_ack}, 2'b01);
    chk("tie_rdata", rdata, 16'hBEEF);
    set_req(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_req(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    chk("tie_idle", {busy, r1_ack, r0_ack}, 0);

    // Top address: write leaves o_rdata alone, read updates it.
    do_txn(0, 1'b1, 8'hFF, 16'h7E57, 16'hBEEF, 1'b0);
    chk("memFF", mem[8'hFF], 16'h7E57);
    do_txn(0, 1'b0, 8'hFF, 16'h0000, 16'h7E57, 1'b0);
    tick();
    chk("rdata_hold", rdata, 16'h7E57);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_access_arbiter
`default_nettype wire

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Sequencer and two-way round-robin arbiter in front of the 256x16 word RAM. It arbitrates between requester 0 (program loader/debug front panel) and requester 1 (CPU bus controller), latches the winner's command, and drives the RAM address, write data and strobes in a fixed SETUP/STROBE/DONE sequence. Because of that sequence, the RAM's edge-triggered write enable always sees stable address and data. It returns read data and a one-cycle acknowledge to the winner.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM word width
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_r0_req  in  1  requester 0 request; held until o_r0_ack
- i_r0_we  in  1  requester 0 op: 1=write, 0=read
- i_r0_addr  in  ADDR_W  requester 0 address
- i_r0_wdata  in  DATA_W  requester 0 write data
- o_r0_ack  out  1  one-cycle completion pulse to requester 0
- i_r1_req, i_r1_we, i_r1_addr, i_r1_wdata, o_r1_ack: same as requester 0, for requester 1
- o_rdata  out  DATA_W  read data of last completed read, valid from ack cycle onward
- o_ram_address  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data (onto RAM data bus)
- o_ram_we  out  1  RAM write strobe
- o_ram_re  out  1  RAM read enable
- i_ram_rdata  in  DATA_W  RAM read data (combinational from RAM)
- o_busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE: if any req is high, the arbiter picks a winner. The winner's we/addr/wdata are latched into command registers, and the FSM goes to SETUP. Otherwise it stays in IDLE.
- Arbitration is round-robin on a 1-bit last-served pointer.
  - Single requester: that requester is granted.
  - Both requesters: the one not last served is granted.
  - Pointer updates at grant. After reset the pointer makes requester 0 win the first tie.
- SETUP: o_ram_address and o_ram_wdata driven from the latch. For a read, o_ram_re=1. Next state is STROBE.
- STROBE:
  - Write: o_ram_we=1.
  - Read: o_ram_re=1, and i_ram_rdata is captured into o_rdata at the end of the cycle.
  - Next state is DONE.
- DONE: o_ram_we=0 and o_ram_re=0. Address and data are still held. The ack of the granted requester is 1. Next state is IDLE.
- o_ram_address/o_ram_wdata change only on entry to SETUP. They are stable SETUP through DONE, so one full cycle of setup and one of hold surround the rising edge of o_ram_we.
- Requests are sampled only in IDLE. A req dropped after grant does not cancel the transaction; the ack is still issued.
- A req held high in the ack cycle is treated as a new request in the following IDLE cycle. Requesters must drop req in the ack cycle to avoid a repeat.
- o_rdata is unchanged by writes and holds its value until the next read's STROBE.

## Timing
- Reset (asynchronous assertion) immediately clears:
  - state to IDLE, pointer to favour r0
  - o_r0_ack, o_r1_ack, o_ram_we, o_ram_re, o_busy = 0
  - o_ram_address, o_ram_wdata, o_rdata = 0
- Reset mid-transaction: the operation is abandoned and no ack is issued. A write is not performed if reset arrives before STROBE.
- Latency: req seen in IDLE at cycle 0; SETUP at 1, STROBE at 2, ack at 3 (both reads and writes).
- Throughput: one transaction per 4 cycles. With both requesters continuously requesting, grants alternate r0, r1, r0, …
- o_ram_we is high for exactly one cycle per write. o_ram_re is high for exactly two cycles per read.
- Ack outputs are registered; both acks are never high together.
- All outputs are registered except o_busy, which may be decoded from state.

## Structure
- Package ram_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, DONE)
  - default ADDR_W/DATA_W constants
- Sub-module rr_arbiter2 holds the 2-input round-robin grant logic and the pointer register. Its inputs are the req vector and a grant-enable qualifier; its output is a one-hot grant.
- Top level: FSM, command latch, output registers.

## Test plan
- Reset, then r0 writes addr 0x05 data 0xBEEF -> o_ram_we high only at cycle 2; address 0x05 and data 0xBEEF stable cycles 1-3; o_r0_ack at cycle 3.
- r1 reads addr 0x05 after the above (RAM model returns 0xBEEF) -> o_ram_re at cycles 1-2; o_rdata=0xBEEF and o_r1_ack at cycle 3.
- r0 and r1 both hold req for 4 transactions -> grant order r0, r1, r0, r1; acks every 4 cycles and never simultaneous.
- r1 write to 0x10, req dropped in SETUP -> transaction still completes, o_r1_ack pulses once, RAM[0x10] updated.
- i_rst_n low during SETUP of an r0 write -> all outputs 0 immediately, no ack, no o_ram_we edge, RAM unchanged; after release, first tie goes to r0.
- r0 write then r0 read to 0xFF (address wrap boundary) -> correct address driven; o_rdata unchanged by the write and updated by the read.
